// File: rtl/tea_pkg.sv
// tea_pkg: shared definitions for the iterative TEA controller.
//   TEA_DELTA    default key-schedule constant
//   tea_state_t  controller states (IDLE / RUN / DONE)
//   tea_key_t    128-bit key, k0 = [127:96] .. k3 = [31:0]
//   tea_blk_t    64-bit block, v0 = [63:32], v1 = [31:0]
//   byteswap32   reverses the byte order of one 32-bit word
//   tea_f        TEA mixing function F(x, a, b, s)
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_t;

  typedef logic [127:0] tea_key_t;
  typedef logic [63:0]  tea_blk_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] s);
    return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
  endfunction

endpackage

// File: rtl/tea_round.sv
// tea_round: one complete TEA cycle (both halves), purely combinational.
// Ports:
//   v        in   64   current block {v0, v1}
//   key      in   128  key {k0, k1, k2, k3}
//   sum      in   32   running sum before this round
//   mode     in   1    0 encrypt, 1 decrypt
//   v_next   out  64   block after this round
//   sum_next out  32   sum to carry into the next round
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = TEA_DELTA
) (
  input  tea_blk_t    v,
  input  tea_key_t    key,
  input  logic [31:0] sum,
  input  logic        mode,
  output tea_blk_t    v_next,
  output logic [31:0] sum_next
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] v0, v1;
  logic [31:0] s_enc;
  logic [31:0] enc_v0, enc_v1;
  logic [31:0] dec_v0, dec_v1;

  assign {k0, k1, k2, k3} = key;
  assign {v0, v1}         = v;

  // Encrypt advances the sum first and uses it for both halves.
  assign s_enc  = sum + DELTA;
  assign enc_v0 = v0 + tea_f(v1, k0, k1, s_enc);
  assign enc_v1 = v1 + tea_f(enc_v0, k2, k3, s_enc);

  // Decrypt undoes the halves in reverse order with the current sum.
  assign dec_v1 = v1 - tea_f(v0, k2, k3, sum);
  assign dec_v0 = v0 - tea_f(dec_v1, k0, k1, sum);

  assign v_next   = mode ? {dec_v0, dec_v1} : {enc_v0, enc_v1};
  assign sum_next = mode ? (sum - DELTA) : s_enc;

endmodule

// File: rtl/tea_iter_ctrl.sv
// tea_iter_ctrl: iterative TEA encrypt/decrypt engine with valid/ready handshakes.
// Holds the key, accepts one 64-bit block, runs one full round per clock for
// ROUNDS cycles, then presents the result until the consumer takes it.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   key_wr, key_sel, key_in    key half write (IDLE only); key_sel 0 -> [127:64]
//   in_valid, in_ready         input handshake; in_mode 0 enc / 1 dec, in_data block
//   out_valid, out_ready       output handshake; out_data result block
//   key_ok                     both key halves written since reset
//   busy                       engine not idle
// Build option: define TEA_BYTESWAP_EN to byte-reverse every 32-bit word of
// in_data, key_in and out_data (little-endian word packing on the bus).
module tea_iter_ctrl
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_wr,
  input  logic        key_sel,
  input  logic [63:0] key_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        key_ok,
  output logic        busy
);

  localparam int          CW       = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS - 1);
  // Decryption starts from the sum encryption finished with.
  localparam logic [31:0] SUM_DEC  = 32'(ROUNDS * DELTA);

  tea_state_t    state_reg;
  tea_key_t      key_reg;
  logic          key_hi_ok_reg, key_lo_ok_reg;
  tea_blk_t      v_reg;
  logic          mode_reg;
  logic [31:0]   sum_reg;
  logic [CW-1:0] cnt_reg;

  tea_blk_t      v_next;
  logic [31:0]   sum_next;
  tea_blk_t      in_blk, out_blk;
  logic [63:0]   key_word;

  // Bus <-> internal word ordering, one 32-bit word per iteration.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
`ifdef TEA_BYTESWAP_EN
      assign in_blk[gi*32 +: 32]   = byteswap32(in_data[gi*32 +: 32]);
      assign key_word[gi*32 +: 32] = byteswap32(key_in[gi*32 +: 32]);
      assign out_blk[gi*32 +: 32]  = byteswap32(v_next[gi*32 +: 32]);
`else
      assign in_blk[gi*32 +: 32]   = in_data[gi*32 +: 32];
      assign key_word[gi*32 +: 32] = key_in[gi*32 +: 32];
      assign out_blk[gi*32 +: 32]  = v_next[gi*32 +: 32];
`endif
    end
  endgenerate

  tea_round #(
    .DELTA (DELTA)
  ) u_round (
    .v        (v_reg),
    .key      (key_reg),
    .sum      (sum_reg),
    .mode     (mode_reg),
    .v_next   (v_next),
    .sum_next (sum_next)
  );

  assign key_ok   = key_hi_ok_reg & key_lo_ok_reg;
  // A key write in the same cycle blocks acceptance so the block never sees a half-updated key.
  assign in_ready = (state_reg == IDLE) & key_ok & ~key_wr;
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      key_reg       <= '0;
      key_hi_ok_reg <= 1'b0;
      key_lo_ok_reg <= 1'b0;
      v_reg         <= '0;
      mode_reg      <= 1'b0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (key_wr) begin
            if (key_sel) begin
              key_reg[63:0] <= key_word;
              key_lo_ok_reg <= 1'b1;
            end else begin
              key_reg[127:64] <= key_word;
              key_hi_ok_reg   <= 1'b1;
            end
          end else if (in_valid && key_ok) begin
            v_reg     <= in_blk;
            mode_reg  <= in_mode;
            cnt_reg   <= '0;
            sum_reg   <= in_mode ? SUM_DEC : 32'd0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          v_reg   <= v_next;
          sum_reg <= sum_next;
          cnt_reg <= cnt_reg + CW'(1);
          // The last round's result goes straight into the output register.
          if (cnt_reg == CNT_LAST) begin
            out_valid <= 1'b1;
            out_data  <= out_blk;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_iter_ctrl.sv
// tb_tea_iter_ctrl: self-checking bench for tea_iter_ctrl with a plain
// loop-based TEA reference model. Honours TEA_BYTESWAP_EN like the design.
module tb_tea_iter_ctrl;

  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;
`ifdef TEA_BYTESWAP_EN
  localparam logic [63:0] ZERO_CT = 64'h0A3AEA41_40A9BA94;
`else
  localparam logic [63:0] ZERO_CT = 64'h41EA3A0A_94BAA940;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_wr = 1'b0;
  logic        key_sel = 1'b0;
  logic [63:0] key_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        key_ok;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  tea_iter_ctrl #(
    .ROUNDS (ROUNDS),
    .DELTA  (DELTA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_wr    (key_wr),
    .key_sel   (key_sel),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .key_ok    (key_ok),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus word order <-> logical word order (identity unless byte swapping is built in).
  function automatic logic [63:0] sw64(input logic [63:0] b);
`ifdef TEA_BYTESWAP_EN
    return {b[39:32], b[47:40], b[55:48], b[63:56], b[7:0], b[15:8], b[23:16], b[31:24]};
`else
    return b;
`endif
  endfunction

  // Reference TEA, straight from the textbook loop; operates on bus-format values.
  function automatic logic [63:0] ref_tea(input logic [127:0] kbus, input logic [63:0] blk,
                                          input logic dec);
    logic [127:0] kk;
    logic [31:0]  k0, k1, k2, k3, y, z, sum;
    kk = {sw64(kbus[127:64]), sw64(kbus[63:0])};
    {k0, k1, k2, k3} = kk;
    {y, z} = sw64(blk);
    if (!dec) begin
      sum = 32'd0;
      for (int i = 0; i < ROUNDS; i++) begin
        sum = sum + DELTA;
        y = y + (((z << 4) + k0) ^ (z + sum) ^ ((z >> 5) + k1));
        z = z + (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
      end
    end else begin
      sum = DELTA * 32'(ROUNDS);
      for (int i = 0; i < ROUNDS; i++) begin
        z = z - (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
        y = y - (((z << 4) + k0) ^ (z + sum) ^ ((z >> 5) + k1));
        sum = sum - DELTA;
      end
    end
    return sw64({y, z});
  endfunction

  task automatic write_key(input logic [127:0] k);
    key_wr = 1'b1; key_sel = 1'b0; key_in = k[127:64];
    tick();
    key_sel = 1'b1; key_in = k[63:0];
    tick();
    key_wr = 1'b0;
  endtask

  // Offer one block, check latency and result, optionally stall the output for
  // 'hold' cycles while pushing blocks and key writes that must all be ignored.
  task automatic send_block(input string tag, input logic [63:0] data, input logic mode,
                            input logic [63:0] exp, input int hold, output int acc_cyc);
    int w;
    int lat;
    in_valid = 1'b1; in_mode = mode; in_data = data; out_ready = (hold == 0);
    #1;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    acc_cyc = cyc;
    // Noise on the input while running must neither be accepted nor disturb the block.
    in_valid = 1'($urandom_range(0, 1));
    in_data  = {$urandom, $urandom};
    in_mode  = 1'($urandom_range(0, 1));
    #1;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_ready_run"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 4 * ROUNDS) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(ROUNDS));
    check({tag, "_data"}, out_data, exp);
    $display("blk %s mode=%0d in=%h out=%h lat=%0d hold=%0d", tag, mode, data, out_data, lat, hold);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      key_wr = 1'b1; key_sel = 1'(i); key_in = {$urandom, $urandom};
      tick();
      check({tag, "_hold_data"}, out_data, exp);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; key_wr = 1'b0; out_ready = 1'b1;
    tick();
    check({tag, "_taken_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_taken_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int a0, a1, w;
    logic [127:0] key;
    logic [63:0]  pt, ct;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_key_ok", 64'(key_ok), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // Only the high key half: a pending block must not be accepted.
    key_wr = 1'b1; key_sel = 1'b0; key_in = 64'd0;
    tick();
    key_wr = 1'b0;
    check("half_key_ok", 64'(key_ok), 64'd0);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 64'd0;
    repeat (3) begin
      tick();
      check("nokey_ready", 64'(in_ready), 64'd0);
      check("nokey_busy", 64'(busy), 64'd0);
    end
    key_wr = 1'b1; key_sel = 1'b1; key_in = 64'd0;
    #1;
    check("keywr_ready", 64'(in_ready), 64'd0);
    tick();
    key_wr = 1'b0;
    #1;
    check("full_key_ok", 64'(key_ok), 64'd1);
    check("full_key_ready", 64'(in_ready), 64'd1);

    // Known-answer vectors with the all-zero key.
    send_block("zero_enc", 64'd0, 1'b0, ZERO_CT, 0, a0);
    send_block("zero_dec", ZERO_CT, 1'b1, 64'd0, 3, a0);

    // Long output stall with ignored key writes, then confirm the key survived.
    send_block("hold_enc", 64'd0, 1'b0, ZERO_CT, 10, a0);
    send_block("after_hold", 64'd0, 1'b0, ZERO_CT, 0, a0);

    // Key write with a valid block pending: the write wins, nothing is accepted.
    key_wr = 1'b1; key_sel = 1'b1; key_in = 64'd0; in_valid = 1'b1; in_data = 64'd0;
    #1;
    check("keyprio_ready", 64'(in_ready), 64'd0);
    tick();
    key_wr = 1'b0; in_valid = 1'b0;
    check("keyprio_busy", 64'(busy), 64'd0);

    // Back-to-back: each block occupies IDLE + ROUNDS x RUN + DONE cycles.
    key = {$urandom, $urandom, $urandom, $urandom};
    write_key(key);
    pt = {$urandom, $urandom};
    send_block("b2b_0", pt, 1'b0, ref_tea(key, pt, 1'b0), 0, a0);
    pt = {$urandom, $urandom};
    send_block("b2b_1", pt, 1'b0, ref_tea(key, pt, 1'b0), 0, a1);
    check("b2b_spacing", 64'(a1 - a0), 64'(ROUNDS + 2));

    // Reset in the middle of a run aborts the block.
    in_valid = 1'b1; in_mode = 1'b0; in_data = {$urandom, $urandom};
    #1;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_key_ok", 64'(key_ok), 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    repeat (ROUNDS + 4) tick();
    check("midrst_no_output", 64'(out_valid), 64'd0);

    // Randomised round trips against the reference model.
    for (int n = 0; n < 100; n++) begin
      if (n % 10 == 0) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        write_key(key);
      end
      pt = {$urandom, $urandom};
      ct = ref_tea(key, pt, 1'b0);
      send_block("rnd_enc", pt, 1'b0, ct, int'($urandom_range(0, 3)), a0);
      send_block("rnd_dec", ct, 1'b1, pt, int'($urandom_range(0, 3)), a0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
